// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: shared FSM states, FP32 field constants and operand helper for fp32_dot_accum.
package fp_acc_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam int ALIGN_W = 27;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_EMIT} state_t;

    // Magnitude {exp,mant} with denormals flushed to zero.
    function automatic logic [30:0] fp_mag(input logic [31:0] x);
        return (x[30:23] == '0) ? 31'd0 : x[30:0];
    endfunction
endpackage

// File: rtl/fp_acc_norm.sv
// fp_acc_norm: normalizes the raw 28-bit sum, rounds (RNE when FP_ACC_RNE_EN is defined,
// truncation otherwise) and clamps exponent overflow to Inf and underflow to zero.
module fp_acc_norm
    import fp_acc_pkg::*;
(
    input  logic [ALIGN_W:0]  i_sum,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic              i_sign,
    output logic [31:0]       o_res
);
`ifdef FP_ACC_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    logic [4:0]         w_lz;
    logic [ALIGN_W-1:0] w_m;
    logic [9:0]         w_e;
    logic [9:0]         w_ef;
    logic               w_up;
    logic [24:0]        w_rnd;

    always_comb begin
        w_lz = 5'd26;
        for (int i = 0; i < ALIGN_W; i++)
            if (i_sum[i]) w_lz = 5'(ALIGN_W - 1 - i);
        w_m = i_sum[ALIGN_W] ? {i_sum[ALIGN_W:2], |i_sum[1:0]} : i_sum[ALIGN_W-1:0] << w_lz;
        w_e = 10'(i_exp) + (i_sum[ALIGN_W] ? 10'd1 : -10'(w_lz));
        w_up = RNE & w_m[2] & (w_m[3] | w_m[1] | w_m[0]);
        w_rnd = {1'b0, w_m[26:3]} + 25'(w_up);
        w_ef = w_e + 10'(w_rnd[24]);
        // A round-up carry leaves 1.000..., i.e. the sum shifted right by one.
        o_res = (i_sum == '0) ? 32'd0 :
                ($signed(w_ef) <= 10'sd0) ? {i_sign, 31'd0} :
                ($signed(w_ef) >= 10'sd255) ? {i_sign, EXP_MAX, {MAN_W{1'b0}}} :
                {i_sign, w_ef[7:0], w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0]};
    end
endmodule

// File: rtl/fp32_dot_accum.sv
// fp32_dot_accum: accumulates LEN FP32 products through an ALIGN/ADD/NORM FSM and holds the sum
// until taken. Define FP_ACC_RNE_EN for round-to-nearest-even; default build truncates.
module fp32_dot_accum
    import fp_acc_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);
    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_acc;
    logic [31:0]        r_opnd;
    logic [7:0]         r_cnt;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [23:0]        r_big_m;
    logic [ALIGN_W-1:0] r_sml;
    logic               r_sub;
    logic [ALIGN_W:0]   r_sum;
    logic               r_spec;
    logic [31:0]        r_spec_val;

    logic [30:0]        w_a;
    logic [30:0]        w_b;
    logic               w_a_big;
    logic [30:0]        w_big;
    logic [30:0]        w_sml;
    logic [23:0]        w_sml_m;
    logic [7:0]         w_diff;
    logic [50:0]        w_shf;
    logic [ALIGN_W-1:0] w_sml_al;
    logic               w_a_inf;
    logic               w_b_inf;
    logic [31:0]        w_spec;
    logic [31:0]        w_norm;

    assign w_a      = fp_mag(r_acc);
    assign w_b      = fp_mag(r_opnd);
    assign w_a_big  = w_a >= w_b;
    assign w_big    = w_a_big ? w_a : w_b;
    assign w_sml    = w_a_big ? w_b : w_a;
    assign w_sml_m  = {|w_sml[30:23], w_sml[22:0]};
    assign w_diff   = w_big[30:23] - w_sml[30:23];
    assign w_shf    = {w_sml_m, 27'd0} >> w_diff;
    // Bits shifted past the round position collapse into the sticky bit.
    assign w_sml_al = (w_diff >= 8'd27) ? {26'd0, |w_sml_m} : {w_shf[50:25], |w_shf[24:0]};
    assign w_a_inf  = r_acc[30:23] == EXP_MAX;
    assign w_b_inf  = r_opnd[30:23] == EXP_MAX;
    assign w_spec   = (w_a_inf && w_b_inf && (r_acc[31] != r_opnd[31])) ? QNAN :
                      {w_a_inf ? r_acc[31] : r_opnd[31], EXP_MAX, {MAN_W{1'b0}}};

    assign in_ready  = rst && (r_state == S_IDLE);
    assign out_valid = r_state == S_EMIT;
    assign out_data  = out_valid ? r_acc : 32'd0;

    fp_acc_norm u_norm (
        .i_sum  (r_sum),
        .i_exp  (r_exp),
        .i_sign (r_sign),
        .o_res  (w_norm)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = in_valid ? S_ALIGN : S_IDLE;
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = (r_cnt + 8'd1 == 8'(LEN)) ? S_EMIT : S_IDLE;
            S_EMIT:  w_next = out_ready ? S_IDLE : S_EMIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_big_m    <= '0;
            r_sml      <= '0;
            r_sub      <= 1'b0;
            r_sum      <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid)
                r_opnd <= in_data;
            if (r_state == S_ALIGN) begin
                r_sign     <= w_a_big ? r_acc[31] : r_opnd[31];
                r_exp      <= w_big[30:23];
                r_big_m    <= {|w_big[30:23], w_big[22:0]};
                r_sml      <= w_sml_al;
                r_sub      <= r_acc[31] != r_opnd[31];
                r_spec     <= w_a_inf || w_b_inf;
                r_spec_val <= w_spec;
            end
            if (r_state == S_ADD)
                r_sum <= r_sub ? {1'b0, r_big_m, 3'b0} - {1'b0, r_sml}
                               : {1'b0, r_big_m, 3'b0} + {1'b0, r_sml};
            if (r_state == S_NORM) begin
                r_acc <= r_spec ? r_spec_val : w_norm;
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_EMIT && out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end
endmodule
